fifo_word_packer: RTL and testbench

Downstream consumer of the team's shift FIFO. Pulls DATA_W-bit entries through the FIFO's read/val interface and packs PACK consecutive entries into one wide word for a valid/ready sink. A flush request emits a partially filled word. Read pulses are throttled so the block never requests more entries than it has room for.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_word_packer.sv | 101 ++++++++++
 tb/tb_fifo_word_packer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the shift FIFO and its downstream word packer.
package fifo_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      OUTPUT  = 1'b1
   } packer_state_t;

   // Bits needed to hold a value in 0..n; also sizes FIFO occupancy pointers.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pulls entries from the shift FIFO and packs PACK of them into one wide word
// for a valid/ready sink; a flush emits the partially filled word.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PACK   = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   output logic                               fifo_read,
   input  logic [DATA_W-1:0]                  fifo_data,
   input  logic                               fifo_val,
   input  logic                               flush,
   output logic [DATA_W*PACK-1:0]             out_data,
   output logic [count_width(PACK)-1:0]       out_count,
   output logic                               out_valid,
   input  logic                               out_ready,
   output packer_state_t                      state_dbg
);

   // Sink handshake: a word transfers on a cycle where out_valid && out_ready;
   // out_data/out_count stay stable while out_valid is high and not yet taken.

   localparam int CW = count_width(PACK);
   localparam logic [CW-1:0] FULL = CW'(PACK);

   packer_state_t                  state;
   logic [CW-1:0]                  count;
   logic                           pending;
   logic                           flush_req;
   logic                           run;
   logic [PACK-1:0][DATA_W-1:0]    lanes;

   logic [CW:0]                    room_used;
   logic                           capture;
   logic [CW-1:0]                  count_next;
   logic                           flush_any;

   // run holds reads off for the first cycle after reset release.
   assign room_used  = {1'b0, count} + {{CW{1'b0}}, pending};
   assign fifo_read  = run && (state == COLLECT) && !flush_req && (room_used < {1'b0, FULL});
   assign capture    = fifo_val && pending;
   assign count_next = count + {{(CW-1){1'b0}}, capture};
   assign flush_any  = flush_req || flush;

   assign out_data  = lanes;
   assign out_valid = (state == OUTPUT);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= COLLECT;
         count     <= '0;
         pending   <= 1'b0;
         flush_req <= 1'b0;
         run       <= 1'b0;
         lanes     <= '0;
         out_count <= '0;
      end else begin
         run     <= 1'b1;
         pending <= fifo_read;
         case (state)
            COLLECT: begin
               for (int k = 0; k < PACK; k++) begin
                  if (capture && (count == CW'(k))) lanes[k] <= fifo_data;
               end
               count <= count_next;
               if (count_next == FULL) begin
                  state     <= OUTPUT;
                  out_count <= FULL;
                  flush_req <= flush_any;
               end else if (flush_any && !fifo_read) begin
                  // No read left in flight after this edge: the partial word is final.
                  if (count_next != '0) begin
                     state     <= OUTPUT;
                     out_count <= count_next;
                     flush_req <= 1'b1;
                  end else begin
                     flush_req <= 1'b0;
                  end
               end else begin
                  flush_req <= flush_any;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state     <= COLLECT;
                  count     <= '0;
                  lanes     <= '0;
                  flush_req <= flush;
               end else begin
                  flush_req <= flush_any;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a 1-cycle-latency FIFO model and a word scoreboard.
module tb_fifo_word_packer;
   import fifo_pkg::*;

   localparam int DATA_W = 8;
   localparam int PACK   = 4;
   localparam int CW     = count_width(PACK);
   localparam int WW     = CW + DATA_W*PACK;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   fifo_read;
   logic [DATA_W-1:0]      fifo_data;
   logic                   fifo_val;
   logic                   flush;
   logic [DATA_W*PACK-1:0] out_data;
   logic [CW-1:0]          out_count;
   logic                   out_valid;
   logic                   out_ready;
   packer_state_t          state_dbg;

   fifo_word_packer #(.DATA_W(DATA_W), .PACK(PACK)) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_read (fifo_read),
      .fifo_data (fifo_data),
      .fifo_val  (fifo_val),
      .flush     (flush),
      .out_data  (out_data),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WW-1:0]     exp_q[$];
   logic [DATA_W-1:0] fifo_q[$];

   logic              accepted = 1'b0;
   logic [DATA_W-1:0] acc_data = '0;
   logic              inject = 1'b0;
   logic [DATA_W-1:0] inject_data = '0;
   logic              arm_read = 1'b0;
   logic              arm_valid = 1'b0;
   int                read_cyc = 0;
   int                valid_cyc = 0;
   int                valid_cycles = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // FIFO model: a read seen in cycle k returns val/data in cycle k+1
   always @(negedge clk) begin
      #1;
      if (!reset) begin
         accepted = 1'b0;
         fifo_val = 1'b0;
      end else begin
         fifo_val = accepted;
         if (accepted) fifo_data = acc_data;
         if (inject) begin
            fifo_val  = 1'b1;
            fifo_data = inject_data;
            inject    = 1'b0;
         end
         accepted = fifo_read && (fifo_q.size() > 0);
         if (accepted) acc_data = fifo_q.pop_front();
         if (fifo_read && arm_read) begin
            read_cyc = cyc;
            arm_read = 1'b0;
         end
      end
   end

   // scoreboard monitor: the word transfers at the next rising edge
   always @(negedge clk) begin
      #1;
      if (out_valid) begin
         valid_cycles++;
         if (arm_valid) begin
            valid_cyc = cyc;
            arm_valid = 1'b0;
         end
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_word: observed %0h expected none", {out_count, out_data});
         end else begin
            check("word", {out_count, out_data}, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [DATA_W-1:0] d);
      fifo_q.push_back(d);
   endtask

   task automatic push_exp(input int n, input logic [DATA_W*PACK-1:0] d);
      exp_q.push_back({CW'(n), d});
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wait_valid"}, out_valid, 1);
   endtask

   initial begin
      int fc;
      int vc;
      reset = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      fifo_val = 1'b0;
      fifo_data = '0;
      tick(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_read", fifo_read, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_data", out_data, 0);
      check("rst_state", state_dbg, COLLECT);

      // full word with sink ready
      load(8'h11); load(8'h22); load(8'h33); load(8'h44);
      push_exp(4, 32'h44332211);
      out_ready = 1'b1;
      arm_read = 1'b1;
      arm_valid = 1'b1;
      reset = 1'b1;
      drain("t1");
      tick(3);
      check("t1_latency", valid_cyc - read_cyc, PACK + 1);
      check("t1_valid_cycles", valid_cycles, 1);

      // backpressure holds the first word and stops reads
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) load(DATA_W'(i));
      push_exp(4, 32'h04030201);
      push_exp(4, 32'h08070605);
      wait_valid("t2");
      repeat (10) begin
         @(negedge clk);
         check("t2_hold_data", {out_count, out_data}, {CW'(4), 32'h04030201});
         check("t2_hold_valid", out_valid, 1);
         check("t2_no_read", fifo_read, 0);
      end
      out_ready = 1'b1;
      drain("t2");

      // FIFO runs empty mid-word
      load(8'hA1); load(8'hA2);
      tick(3);
      repeat (5) begin
         @(negedge clk);
         check("t3_reread", fifo_read, 1);
         check("t3_no_valid", out_valid, 0);
      end
      push_exp(4, 32'hA4A3A2A1);
      load(8'hA3); load(8'hA4);
      drain("t3");

      // flush of a partial word, then flush with nothing collected
      load(8'h5A); load(8'h6B);
      push_exp(2, 32'h00006B5A);
      tick(4);
      arm_valid = 1'b1;
      fc = cyc;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drain("t4");
      check("t4_flush_latency", (valid_cyc - fc) <= 2, 1);
      tick(2);
      vc = valid_cycles;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      tick(6);
      check("t4_empty_flush_no_valid", valid_cycles, vc);
      check("t4_empty_flush_reads", fifo_read, 1);

      // flush in the same cycle as the last val
      load(8'h5A);
      tick(3);
      push_exp(2, 32'h00007C5A);
      load(8'h7C);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drain("t5");

      // reset mid-word discards partial data; stray val after release is ignored
      load(8'h91); load(8'h92); load(8'h93);
      tick(5);
      reset = 1'b0;
      #1;
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_fifo_read", fifo_read, 0);
      check("t6_rst_out_count", out_count, 0);
      check("t6_rst_out_data", out_data, 0);
      tick(2);
      reset = 1'b1;
      inject_data = 8'hEE;
      inject = 1'b1;
      load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
      push_exp(4, 32'hB4B3B2B1);
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
